// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// funct3 decoding helpers used by mem_lsu and mem_lsu_align.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = 4;

  // Loads allow B/H/W/BU/HU; stores only B/H/W.
  function automatic logic f3_illegal(logic is_store, logic [2:0] f3);
    if (is_store) return f3[2] || (f3[1:0] == 2'b11);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic f3_misaligned(logic [2:0] f3, logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational byte-lane steering for stores and lane extract/extend for loads.
// Stores use the live request fields, loads use the fields captured at issue.
module mem_lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]         st_size,
  input  logic [1:0]         st_offset,
  input  logic [BUS_DW-1:0]  st_wdata,
  output logic [BUS_DW-1:0]  st_data,
  output logic [BUS_BEW-1:0] st_be,
  input  logic [2:0]         ld_funct3,
  input  logic [1:0]         ld_offset,
  input  logic [BUS_DW-1:0]  ld_rdata,
  output logic [BUS_DW-1:0]  ld_data
);

  logic [BUS_DW-1:0] ld_lane;

  always_comb begin
    st_data = st_wdata;
    st_be   = 4'hF;
    case (st_size)
      2'b00: begin
        st_data = {4{st_wdata[7:0]}};
        st_be   = 4'b0001 << st_offset;
      end
      2'b01: begin
        st_data = {2{st_wdata[15:0]}};
        st_be   = 4'b0011 << {st_offset[1], 1'b0};
      end
      default: ;
    endcase
  end

  // The addressed lane is shifted down to bit 0 before extension.
  always_comb begin
    ld_lane = ld_rdata >> {ld_offset, 3'b000};
    ld_data = ld_rdata;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_lane[7]}}, ld_lane[7:0]};
      F3_H:    ld_data = {{16{ld_lane[15]}}, ld_lane[15:0]};
      F3_BU:   ld_data = {24'h0, ld_lane[7:0]};
      F3_HU:   ld_data = {16'h0, ld_lane[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one bus transaction per memory op, stalling until done.
// Define LSU_MISALIGN_EXC_EN to trap misaligned H/W accesses instead of forcing alignment.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_rvalid,
  output logic [31:0] o_rdata,
  output logic        o_accessFault,
  output logic        o_excMisalign,
  output logic        o_busReq,
  output logic        o_busWe,
  output logic [31:0] o_busAddr,
  output logic [3:0]  o_busBe,
  output logic [31:0] o_busWdata,
  input  logic        i_busGnt,
  input  logic        i_busRvalid,
  input  logic [31:0] i_busRdata,
  input  logic        i_busErr
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  lsu_state_e state, state_next;

  logic             op;
  logic             bad_f3;
  logic             mis;
  logic [1:0]       off_in;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             is_load_q;
  logic             fault_q;
  logic             misalign_q;
  logic [TMO_W-1:0] cnt;
  logic [31:0]      rdata_q;
  logic             bus_we_q;
  logic [31:0]      bus_addr_q;
  logic [3:0]       bus_be_q;
  logic [31:0]      bus_wdata_q;
  logic [31:0]      st_data;
  logic [3:0]       st_be;
  logic [31:0]      ld_data;

  assign op     = i_valid & (i_memRead | i_memWrite);
  assign bad_f3 = f3_illegal(i_memWrite, i_funct3);

`ifdef LSU_MISALIGN_EXC_EN
  assign mis    = ~bad_f3 & f3_misaligned(i_funct3, i_addr[1:0]);
  assign off_in = i_addr[1:0];
`else
  assign mis = 1'b0;
  always_comb begin
    off_in = i_addr[1:0];
    if (i_funct3[1:0] == 2'b01) off_in[0] = 1'b0;
    if (i_funct3[1:0] == 2'b10) off_in = 2'b00;
  end
`endif

  mem_lsu_align u_align (
    .st_size   (i_funct3[1:0]),
    .st_offset (off_in),
    .st_wdata  (i_wdata),
    .st_data   (st_data),
    .st_be     (st_be),
    .ld_funct3 (f3_q),
    .ld_offset (off_q),
    .ld_rdata  (i_busRdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      is_load_q   <= 1'b0;
      fault_q     <= 1'b0;
      misalign_q  <= 1'b0;
      cnt         <= '0;
      rdata_q     <= 32'h0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (op) begin
          f3_q        <= i_funct3;
          off_q       <= off_in;
          is_load_q   <= i_memRead;
          fault_q     <= bad_f3;
          misalign_q  <= mis;
          bus_we_q    <= i_memWrite;
          bus_addr_q  <= {i_addr[31:2], 2'b00};
          bus_be_q    <= i_memWrite ? st_be : 4'hF;
          bus_wdata_q <= i_memWrite ? st_data : 32'h0;
        end
        REQ: if (i_busGnt) cnt <= '0;
        // A response after the timeout fires lands in IDLE/DONE and is ignored.
        WAIT: begin
          if (i_busRvalid) begin
            fault_q <= i_busErr;
            if (!i_busErr && is_load_q) rdata_q <= ld_data;
          end else if (cnt == TMO_LAST) begin
            fault_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (op) state_next = (bad_f3 || mis) ? DONE : REQ;
      REQ:  if (i_busGnt) state_next = WAIT;
      WAIT: if (i_busRvalid || cnt == TMO_LAST) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign o_stall       = ((state == IDLE) & op) | (state == REQ) | (state == WAIT);
  assign o_busReq      = (state == REQ);
  assign o_rvalid      = (state == DONE) & ~fault_q & ~misalign_q;
  assign o_accessFault = (state == DONE) & fault_q;
`ifdef LSU_MISALIGN_EXC_EN
  assign o_excMisalign = (state == DONE) & misalign_q;
`else
  assign o_excMisalign = 1'b0;
`endif
  assign o_rdata    = rdata_q;
  assign o_busWe    = bus_we_q;
  assign o_busAddr  = bus_addr_q;
  assign o_busBe    = bus_be_q;
  assign o_busWdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a scripted bus slave.
// Expected values are hand-computed; honours LSU_MISALIGN_EXC_EN when defined.
module tb_mem_lsu;

  localparam int TMO = 256;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid, i_memRead, i_memWrite;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata;
  logic        o_stall, o_rvalid, o_accessFault, o_excMisalign;
  logic [31:0] o_rdata;
  logic        o_busReq, o_busWe;
  logic [31:0] o_busAddr, o_busWdata;
  logic [3:0]  o_busBe;
  logic        i_busGnt, i_busRvalid, i_busErr;
  logic [31:0] i_busRdata;

  int n_cmp = 0;
  int n_bad = 0;

  int          r_stall, r_lat, r_req, r_pulses;
  logic        r_done, r_rvalid, r_fault, r_mis, r_stable, r_we;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;

  mem_lsu #(.TIMEOUT_CYC(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_memRead(i_memRead),
    .i_memWrite(i_memWrite), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_accessFault(o_accessFault), .o_excMisalign(o_excMisalign),
    .o_busReq(o_busReq), .o_busWe(o_busWe), .o_busAddr(o_busAddr), .o_busBe(o_busBe),
    .o_busWdata(o_busWdata), .i_busGnt(i_busGnt), .i_busRvalid(i_busRvalid),
    .i_busRdata(i_busRdata), .i_busErr(i_busErr)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one memory op; the slave grants after gnt_dly REQ cycles and responds after rsp_dly WAIT cycles.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int gnt_dly, input int rsp_dly,
                               input logic [31:0] rsp_data, input logic rsp_err, input int max_cyc);
    logic in_wait;
    int   req_n, wait_n;
    i_valid = 1'b1; i_memRead = rd; i_memWrite = wr; i_funct3 = f3;
    i_addr = addr; i_wdata = wdata; i_busRdata = rsp_data; i_busErr = rsp_err;
    r_stall = 0; r_lat = 0; r_req = 0; r_pulses = 0; r_done = 1'b0;
    r_rvalid = 1'b0; r_fault = 1'b0; r_mis = 1'b0; r_stable = 1'b1; r_we = 1'b0;
    r_addr = 32'h0; r_wdata = 32'h0; r_rdata = 32'h0; r_be = 4'h0;
    in_wait = 1'b0; req_n = 0; wait_n = 0;
    for (int c = 0; c < max_cyc && !r_done; c++) begin
      i_busGnt    = o_busReq && (req_n >= gnt_dly);
      i_busRvalid = in_wait && (wait_n >= rsp_dly);
      #1;
      r_lat++;
      if (o_stall) r_stall++;
      if (o_busReq) begin
        if (req_n == 0) begin
          r_addr = o_busAddr; r_be = o_busBe; r_wdata = o_busWdata; r_we = o_busWe;
        end else if (o_busAddr !== r_addr || o_busBe !== r_be ||
                     o_busWdata !== r_wdata || o_busWe !== r_we) begin
          r_stable = 1'b0;
        end
        req_n++;
      end
      if (in_wait) wait_n++;
      r_pulses = r_pulses + int'(o_rvalid) + int'(o_accessFault) + int'(o_excMisalign);
      if (o_rvalid || o_accessFault || o_excMisalign) begin
        r_done = 1'b1; r_rvalid = o_rvalid; r_fault = o_accessFault; r_mis = o_excMisalign;
        r_rdata = o_rdata;
        i_valid = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0;
      end
      if (o_busReq && i_busGnt) in_wait = 1'b1;
      else if (in_wait && i_busRvalid) in_wait = 1'b0;
      @(posedge i_clk); #1;
    end
    r_req = req_n;
    i_busGnt = 1'b0; i_busRvalid = 1'b0; i_busErr = 1'b0;
    i_valid = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0;
    if (!r_done) checkOutput("op_completion_bound", 32'd0, 32'd1);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_memRead = 1'b0; i_memWrite = 1'b0; i_funct3 = 3'b000;
    i_addr = 32'h0; i_wdata = 32'h0; i_busGnt = 1'b0; i_busRvalid = 1'b0;
    i_busErr = 1'b0; i_busRdata = 32'h0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_stall", {31'h0, o_stall}, 32'h0);
    checkOutput("rst_req", {31'h0, o_busReq}, 32'h0);
    checkOutput("rst_addr", o_busAddr, 32'h0);
    checkOutput("rst_be", {28'h0, o_busBe}, 32'h0);
    checkOutput("rst_rdata", o_rdata, 32'h0);
    checkOutput("rst_pulses", {29'h0, o_rvalid, o_accessFault, o_excMisalign}, 32'h0);
    i_rst = 1'b0;

    applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, 20);
    checkOutput("lw_addr", r_addr, 32'h100);
    checkOutput("lw_be", {28'h0, r_be}, 32'hF);
    checkOutput("lw_we", {31'h0, r_we}, 32'h0);
    checkOutput("lw_stall", r_stall, 32'd3);
    checkOutput("lw_latency", r_lat, 32'd4);
    checkOutput("lw_rvalid", {31'h0, r_rvalid}, 32'h1);
    checkOutput("lw_rdata", r_rdata, 32'hDEADBEEF);
    checkOutput("lw_pulses", r_pulses, 32'd1);

    applyStimulus(1, 0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80000000, 0, 20);
    checkOutput("lb_addr", r_addr, 32'h200);
    checkOutput("lb_rdata", r_rdata, 32'hFFFFFF80);
    applyStimulus(1, 0, 3'b100, 32'h203, 32'h0, 0, 0, 32'h80000000, 0, 20);
    checkOutput("lbu_rdata", r_rdata, 32'h00000080);

    applyStimulus(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 32'h0, 0, 20);
    checkOutput("sh_addr", r_addr, 32'h100);
    checkOutput("sh_be", {28'h0, r_be}, 32'hC);
    checkOutput("sh_wdata", r_wdata, 32'hABCDABCD);
    checkOutput("sh_we", {31'h0, r_we}, 32'h1);
    checkOutput("sh_rvalid", {31'h0, r_rvalid}, 32'h1);
    checkOutput("sh_rdata_kept", o_rdata, 32'h00000080);

    applyStimulus(0, 1, 3'b000, 32'h001, 32'h000000EF, 1, 2, 32'h0, 0, 20);
    checkOutput("sb_be", {28'h0, r_be}, 32'h2);
    checkOutput("sb_wdata", r_wdata, 32'hEFEFEFEF);
    checkOutput("sb_stall", r_stall, 32'd6);

    applyStimulus(1, 0, 3'b001, 32'h202, 32'h0, 0, 0, 32'h80011234, 0, 20);
    checkOutput("lh_rdata", r_rdata, 32'hFFFF8001);
    applyStimulus(1, 0, 3'b101, 32'h202, 32'h0, 0, 0, 32'h80011234, 0, 20);
    checkOutput("lhu_rdata", r_rdata, 32'h00008001);

    applyStimulus(1, 0, 3'b010, 32'h300, 32'h0, 5, 0, 32'h12345678, 1, 30);
    checkOutput("err_req_cycles", r_req, 32'd6);
    checkOutput("err_fields_stable", {31'h0, r_stable}, 32'h1);
    checkOutput("err_addr", r_addr, 32'h300);
    checkOutput("err_fault", {31'h0, r_fault}, 32'h1);
    checkOutput("err_rvalid", {31'h0, r_rvalid}, 32'h0);
    checkOutput("err_rdata_kept", r_rdata, 32'h00008001);

    applyStimulus(1, 0, 3'b010, 32'h304, 32'h0, 0, 100000, 32'h0, 0, TMO + 20);
    checkOutput("tmo_fault", {31'h0, r_fault}, 32'h1);
    checkOutput("tmo_stall", r_stall, TMO + 2);
    i_busRvalid = 1'b1; i_busRdata = 32'h11111111;
    #1;
    checkOutput("late_stall", {31'h0, o_stall}, 32'h0);
    @(posedge i_clk); #1;
    i_busRvalid = 1'b0;
    checkOutput("late_pulses", {29'h0, o_rvalid, o_accessFault, o_excMisalign}, 32'h0);
    checkOutput("late_rdata", o_rdata, 32'h00008001);

    applyStimulus(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0, 0, 20);
    checkOutput("ill_ld_fault", {31'h0, r_fault}, 32'h1);
    checkOutput("ill_ld_noreq", r_req, 32'd0);
    checkOutput("ill_ld_latency", r_lat, 32'd2);
    applyStimulus(0, 1, 3'b100, 32'h100, 32'h0, 0, 0, 32'h0, 0, 20);
    checkOutput("ill_st_fault", {31'h0, r_fault}, 32'h1);
    checkOutput("ill_st_noreq", r_req, 32'd0);

    applyStimulus(1, 0, 3'b010, 32'h102, 32'h0, 0, 0, 32'hCAFEF00D, 0, 20);
`ifdef LSU_MISALIGN_EXC_EN
    checkOutput("mis_exc", {31'h0, r_mis}, 32'h1);
    checkOutput("mis_noreq", r_req, 32'd0);
    checkOutput("mis_rdata_kept", r_rdata, 32'h00008001);
`else
    checkOutput("mis_exc", {31'h0, r_mis}, 32'h0);
    checkOutput("mis_addr", r_addr, 32'h100);
    checkOutput("mis_rdata", r_rdata, 32'hCAFEF00D);
`endif

    // Reset while an access sits in WAIT.
    i_valid = 1'b1; i_memRead = 1'b1; i_funct3 = 3'b010; i_addr = 32'h400; i_busGnt = 1'b1;
    @(posedge i_clk); #1;
    checkOutput("mr_req", {31'h0, o_busReq}, 32'h1);
    @(posedge i_clk); #1;
    i_busGnt = 1'b0;
    @(posedge i_clk); #1;
    checkOutput("mr_wait_stall", {31'h0, o_stall}, 32'h1);
    i_rst = 1'b1; i_valid = 1'b0; i_memRead = 1'b0;
    @(posedge i_clk); #1;
    checkOutput("mr_stall", {31'h0, o_stall}, 32'h0);
    checkOutput("mr_addr", o_busAddr, 32'h0);
    checkOutput("mr_be", {28'h0, o_busBe}, 32'h0);
    checkOutput("mr_rdata", o_rdata, 32'h0);
    i_rst = 1'b0; i_busRvalid = 1'b1; i_busRdata = 32'h55555555;
    @(posedge i_clk); #1;
    i_busRvalid = 1'b0;
    checkOutput("mr_drop", {29'h0, o_rvalid, o_accessFault, o_excMisalign}, 32'h0);
    checkOutput("mr_drop_rdata", o_rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
